// File: rtl/morse_vga_renderer.sv
// Morse-code VGA renderer: MAX_SYMS blue slot boxes with white dot/dash bars and a
// red playback cursor. Codes enter through valid/ready and are swapped in only at frame_start.
module morse_vga_renderer #(
  parameter int MAX_SYMS    = 4,
  parameter int SLOT_X0     = 120,
  parameter int SLOT_PITCH  = 120,
  parameter int SLOT_W      = 60,
  parameter int BOX_Y0      = 200,
  parameter int BOX_Y1      = 280,
  parameter int BAR_Y0      = 230,
  parameter int BAR_Y1      = 250,
  parameter int DOT_HW      = 10,
  parameter int DASH_HW     = 20,
  parameter int STEP_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_en,
  input  logic [9:0]          CounterX,
  input  logic [9:0]          CounterY,
  input  logic                inDisplayArea,
  input  logic                frame_start,
  input  logic                code_valid,
  output logic                code_ready,
  input  logic [3:0]          code_len,
  input  logic [MAX_SYMS-1:0] code_bits,
  input  logic                play_en,
  output logic                busy,
  output logic                vga_r,
  output logic                vga_g,
  output logic                vga_b
);

  localparam int LW = $clog2(MAX_SYMS + 1);
  localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  if (MAX_SYMS < 1 || MAX_SYMS > 8) begin : g_bad_syms
    $error("morse_vga_renderer: MAX_SYMS must be 1..8");
  end
  if (SLOT_X0 + (MAX_SYMS - 1) * SLOT_PITCH + SLOT_W > 639) begin : g_bad_width
    $error("morse_vga_renderer: slots exceed the visible width");
  end
  if (DASH_HW > SLOT_W / 2 || STEP_FRAMES < 1) begin : g_bad_geom
    $error("morse_vga_renderer: dash wider than box or STEP_FRAMES < 1");
  end

  typedef enum logic {SHOW, PLAY} state_e;

  state_e              r_state, w_next_state;
  logic                r_pending;
  logic [LW-1:0]       r_shadow_len, r_active_len;
  logic [MAX_SYMS-1:0] r_shadow_bits, r_active_bits;
  logic [LW-1:0]       r_cursor;
  logic [FW-1:0]       r_frame_cnt;
  logic [2:0]          r_rgb;

  logic          w_accept, w_commit, w_step, w_last_frame, w_last_sym;
  logic [LW-1:0] w_len_clamped;
  logic          w_box, w_bar, w_red;
  logic [2:0]    w_rgb;

  assign w_accept      = code_valid & code_ready;
  // A code accepted in the same clk as frame_start is not yet pending, so it waits a frame.
  assign w_commit      = frame_start & r_pending;
  assign w_step        = frame_start & ~w_commit & (r_state == PLAY);
  assign w_last_frame  = (r_frame_cnt == FW'(STEP_FRAMES - 1));
  assign w_last_sym    = (r_cursor == r_active_len - LW'(1));
  assign w_len_clamped = (int'(code_len) > MAX_SYMS) ? LW'(MAX_SYMS) : LW'(code_len);

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SHOW;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_commit) begin
      w_next_state = play_en ? PLAY : SHOW;
    end else if (w_step) begin
      if (r_active_len == '0 || (w_last_frame && w_last_sym)) w_next_state = SHOW;
    end
  end

  always_comb begin
    code_ready = ~r_pending;
    busy       = r_pending | (r_state == PLAY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= 1'b0;
      r_shadow_len  <= '0;
      r_shadow_bits <= '0;
      r_active_len  <= '0;
      r_active_bits <= '0;
      r_cursor      <= '0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_commit) begin
        r_active_len  <= r_shadow_len;
        r_active_bits <= r_shadow_bits;
        r_pending     <= 1'b0;
        r_cursor      <= '0;
        r_frame_cnt   <= '0;
      end else if (w_step && r_active_len != '0) begin
        if (w_last_frame) begin
          r_frame_cnt <= '0;
          r_cursor    <= w_last_sym ? '0 : r_cursor + LW'(1);
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end
      if (w_accept) begin
        r_shadow_len  <= w_len_clamped;
        r_shadow_bits <= code_bits;
        r_pending     <= 1'b1;
      end
    end
  end

  // Pixel classification over all slots; bars are only drawn for committed symbols.
  always_comb begin
    w_box = 1'b0;
    w_bar = 1'b0;
    w_red = 1'b0;
    for (int i = 0; i < MAX_SYMS; i++) begin
      int x, y, left, cx, hw;
      x    = int'(CounterX);
      y    = int'(CounterY);
      left = SLOT_X0 + i * SLOT_PITCH;
      cx   = left + SLOT_W / 2;
      hw   = r_active_bits[i] ? DASH_HW : DOT_HW;
      if (y >= BOX_Y0 && y <= BOX_Y1 && x >= left && x <= left + SLOT_W) w_box = 1'b1;
      if (i < int'(r_active_len) && y >= BAR_Y0 && y <= BAR_Y1 &&
          x >= cx - hw && x <= cx + hw) begin
        w_bar = 1'b1;
        if (r_state == PLAY && i == int'(r_cursor)) w_red = 1'b1;
      end
    end
  end

  always_comb begin
    w_rgb = 3'b000;
    if (inDisplayArea) begin
      if (w_red)      w_rgb = 3'b100;
      else if (w_bar) w_rgb = 3'b111;
      else if (w_box) w_rgb = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= 3'b000;
    end else if (pix_en) begin
      r_rgb <= w_rgb;
    end
  end

  assign {vga_r, vga_g, vga_b} = r_rgb;

endmodule
